// File: rtl/hlsm_dp_param.sv
// Parametrised HLSM datapath: z = max-select(a+b, a+c), x = a*c - (a+b),
// with configurable width, signedness, multiply latency and a sticky overflow flag.
module hlsm_dp_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SIGNED     = 1'b0,
  parameter int unsigned MUL_LAT    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] z,
  output logic [DATA_WIDTH-1:0] x,
  output logic                  Ovf
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    START_WAIT = 3'd0,
    S_ADD      = 3'd1,
    S_MUL      = 3'd2,
    S_CMP      = 3'd3,
    S_SEL      = 3'd4,
    S_OUT      = 3'd5,
    FINAL      = 3'd6
  } state_t;

  state_t state, state_n;

  logic [W-1:0]  ar, br, cr;
  logic [W-1:0]  d, e, f;
  logic [W-1:0]  zrin, xrin;
  logic          g;
  logic [CW-1:0] cnt;

  logic ld_ops, ld_add, ld_mul, dec_mul, ld_cmp, ld_sel, ld_out, ld_fin;

  // One extra bit of sign/zero extension makes every overflow test a
  // "does the exact result still fit in W bits" check, whatever the signedness.
  function automatic logic [W:0] ext1(input logic [W-1:0] v);
    ext1 = SIGNED ? {v[W-1], v} : {1'b0, v};
  endfunction

  function automatic logic [PW-1:0] ext2(input logic [W-1:0] v);
    ext2 = SIGNED ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
  endfunction

  logic [W:0]    sum_d, sum_e, diff_x;
  logic [PW-1:0] prod;
  logic          ovf_d, ovf_e, ovf_p, ovf_x, gt;

  assign sum_d  = ext1(ar) + ext1(br);
  assign sum_e  = ext1(ar) + ext1(cr);
  assign prod   = ext2(ar) * ext2(cr);
  assign diff_x = ext1(f) - ext1(d);

  assign ovf_d  = (sum_d  != ext1(sum_d[W-1:0]));
  assign ovf_e  = (sum_e  != ext1(sum_e[W-1:0]));
  assign ovf_p  = (prod   != ext2(prod[W-1:0]));
  assign ovf_x  = (diff_x != ext1(diff_x[W-1:0]));
  assign gt     = ($signed(ext1(d)) > $signed(ext1(e)));

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= START_WAIT;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      START_WAIT: if (Start) state_n = S_ADD;
      S_ADD:      state_n = S_MUL;
      S_MUL:      if (cnt == '0) state_n = S_CMP;
      S_CMP:      state_n = S_SEL;
      S_SEL:      state_n = S_OUT;
      S_OUT:      state_n = FINAL;
      FINAL:      state_n = START_WAIT;
      default:    state_n = START_WAIT;
    endcase
  end

  // Per-state datapath load strobes
  always_comb begin
    ld_ops  = 1'b0;
    ld_add  = 1'b0;
    ld_mul  = 1'b0;
    dec_mul = 1'b0;
    ld_cmp  = 1'b0;
    ld_sel  = 1'b0;
    ld_out  = 1'b0;
    ld_fin  = 1'b0;
    case (state)
      START_WAIT: ld_ops = Start;
      S_ADD:      ld_add = 1'b1;
      S_MUL: begin
        ld_mul  = (cnt == '0);
        dec_mul = (cnt != '0);
      end
      S_CMP:      ld_cmp = 1'b1;
      S_SEL:      ld_sel = 1'b1;
      S_OUT:      ld_out = 1'b1;
      FINAL:      ld_fin = 1'b1;
      default:    ld_ops = 1'b0;
    endcase
  end

  // Datapath registers, handshake flags and sticky overflow
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ar   <= '0;
      br   <= '0;
      cr   <= '0;
      d    <= '0;
      e    <= '0;
      f    <= '0;
      g    <= 1'b0;
      zrin <= '0;
      xrin <= '0;
      cnt  <= '0;
      z    <= '0;
      x    <= '0;
      Done <= 1'b0;
      Busy <= 1'b0;
      Ovf  <= 1'b0;
    end else begin
      if (ld_ops) begin
        ar   <= a;
        br   <= b;
        cr   <= c;
        Done <= 1'b0;
        Busy <= 1'b1;
        Ovf  <= 1'b0;
      end
      if (ld_add) begin
        d   <= sum_d[W-1:0];
        e   <= sum_e[W-1:0];
        cnt <= CW'(MUL_LAT - 1);
        Ovf <= Ovf | ovf_d | ovf_e;
      end
      if (dec_mul) cnt <= cnt - CW'(1);
      if (ld_mul) begin
        f   <= prod[W-1:0];
        Ovf <= Ovf | ovf_p;
      end
      if (ld_cmp) g <= gt;
      if (ld_sel) begin
        zrin <= g ? d : e;
        xrin <= diff_x[W-1:0];
        Ovf  <= Ovf | ovf_x;
      end
      if (ld_out) begin
        z <= zrin;
        x <= xrin;
      end
      if (ld_fin) begin
        Done <= 1'b1;
        Busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hlsm_dp_param.sv
// Bench for hlsm_dp_param: four configurations share one stimulus stream and
// are checked cycle by cycle against an arithmetic reference model.
module tb_hlsm_dp_param;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] a, b, c;

  logic [31:0] zo [4];
  logic [31:0] xo [4];
  logic        bo [4];
  logic        dn [4];
  logic        ov [4];
  logic [7:0]  z8, x8;

  int n_assert = 0;
  int n_fail   = 0;

  // Configuration of each instance, mirrored for the model
  int dw [4] = '{32, 32, 32, 8};
  bit sg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int ml [4] = '{1, 1, 3, 1};

  longint unsigned pz [4];
  longint unsigned px [4];

  always #5 Clk = ~Clk;

  hlsm_dp_param #(.DATA_WIDTH(32), .SIGNED(1'b0), .MUL_LAT(1)) u_u32 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
    .Busy(bo[0]), .Done(dn[0]), .z(zo[0]), .x(xo[0]), .Ovf(ov[0]));

  hlsm_dp_param #(.DATA_WIDTH(32), .SIGNED(1'b1), .MUL_LAT(1)) u_s32 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
    .Busy(bo[1]), .Done(dn[1]), .z(zo[1]), .x(xo[1]), .Ovf(ov[1]));

  hlsm_dp_param #(.DATA_WIDTH(32), .SIGNED(1'b0), .MUL_LAT(3)) u_u32m3 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
    .Busy(bo[2]), .Done(dn[2]), .z(zo[2]), .x(xo[2]), .Ovf(ov[2]));

  hlsm_dp_param #(.DATA_WIDTH(8), .SIGNED(1'b0), .MUL_LAT(1)) u_u8 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
    .Busy(bo[3]), .Done(dn[3]), .z(z8), .x(x8), .Ovf(ov[3]));

  assign zo[3] = {24'd0, z8};
  assign xo[3] = {24'd0, x8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint unsigned v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: exact integer arithmetic, results reduced mod 2^w,
  // overflow = some exact intermediate does not fit the w-bit number range.
  task automatic model(input int w, input bit s, input logic [31:0] ia, ib, ic,
                       output longint unsigned oz, output longint unsigned ox,
                       output bit ovf);
    longint unsigned m, ua, ub, uc, d, e, f;
    longint sa, sb, sc, sd, se, sp, sdx, lo, hi;
    bit g;
    m  = (64'd1 << w) - 64'd1;
    ua = 64'(ia) & m;
    ub = 64'(ib) & m;
    uc = 64'(ic) & m;
    if (!s) begin
      d   = (ua + ub) & m;
      e   = (ua + uc) & m;
      f   = (ua * uc) & m;
      ovf = (ua + ub > m) || (ua + uc > m) || (ua * uc > m) || (f < d);
      g   = d > e;
      ox  = (f - d) & m;
    end else begin
      lo  = -(longint'(1) << (w - 1));
      hi  = (longint'(1) << (w - 1)) - 1;
      sa  = sx(ua, w);
      sb  = sx(ub, w);
      sc  = sx(uc, w);
      sd  = sa + sb;
      se  = sa + sc;
      sp  = sa * sc;
      d   = longint'(sd) & m;
      e   = longint'(se) & m;
      f   = longint'(sp) & m;
      g   = sx(d, w) > sx(e, w);
      sdx = sx(f, w) - sx(d, w);
      ovf = (sd < lo) || (sd > hi) || (se < lo) || (se > hi) ||
            (sp < lo) || (sp > hi) || (sdx < lo) || (sdx > hi);
      ox  = longint'(sdx) & m;
    end
    oz = g ? d : e;
  endtask

  task automatic chk_zero(input string when);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s dut%0d z", when, i), 64'(zo[i]), 64'd0);
      chk($sformatf("%s dut%0d x", when, i), 64'(xo[i]), 64'd0);
      chk($sformatf("%s dut%0d done", when, i), 64'(dn[i]), 64'd0);
      chk($sformatf("%s dut%0d busy", when, i), 64'(bo[i]), 64'd0);
      chk($sformatf("%s dut%0d ovf", when, i), 64'(ov[i]), 64'd0);
    end
  endtask

  // One transaction: Start for one edge (E0), then check every cycle up to E13.
  // glitch_k: cycle whose edge sees a stray Start with fresh operands.
  // rst_k: cycle after which an asynchronous reset pulse abandons the run.
  task automatic run(input logic [31:0] ia, ib, ic, input int glitch_k, input int rst_k);
    longint unsigned ez [4];
    longint unsigned ex [4];
    bit eo [4];
    int lat;
    bit was_reset;
    was_reset = 1'b0;
    for (int i = 0; i < 4; i++) model(dw[i], sg[i], ia, ib, ic, ez[i], ex[i], eo[i]);
    a = ia;
    b = ib;
    c = ic;
    Start = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      if (k == glitch_k) begin
        Start = 1'b1;
        a = $urandom;
        b = $urandom;
        c = $urandom;
      end
      @(posedge Clk);
      #1;
      Start = 1'b0;
      if (k == rst_k) begin
        #2 Rst = 1'b1;
        #1 chk_zero($sformatf("async_rst k%0d", k));
        #1 Rst = 1'b0;
        was_reset = 1'b1;
        break;
      end
      for (int i = 0; i < 4; i++) begin
        lat = ml[i] + 5;
        chk($sformatf("dut%0d k%0d busy", i, k), 64'(bo[i]), 64'(k < lat));
        chk($sformatf("dut%0d k%0d done", i, k), 64'(dn[i]), 64'(k >= lat));
        chk($sformatf("dut%0d k%0d z", i, k), 64'(zo[i]), (k >= lat - 1) ? ez[i] : pz[i]);
        chk($sformatf("dut%0d k%0d x", i, k), 64'(xo[i]), (k >= lat - 1) ? ex[i] : px[i]);
        if (k == 0) chk($sformatf("dut%0d k0 ovf_clr", i), 64'(ov[i]), 64'd0);
        if (k >= lat) chk($sformatf("dut%0d k%0d ovf", i, k), 64'(ov[i]), 64'(eo[i]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      pz[i] = was_reset ? 64'd0 : ez[i];
      px[i] = was_reset ? 64'd0 : ex[i];
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    Rst   = 1'b1;
    Start = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      pz[i] = 64'd0;
      px[i] = 64'd0;
    end
    #3 chk_zero("por");
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(posedge Clk);
    #1;

    run(32'd5, 32'd3, 32'd2, -1, -1);
    chk("plan u32 z", 64'(zo[0]), 64'd8);
    chk("plan u32 x", 64'(xo[0]), 64'd2);
    run(32'hFFFF_FFFC, 32'd1, 32'd3, -1, -1);
    chk("plan s32 x", 64'(xo[1]), 64'hFFFF_FFF7);
    chk("plan s32 ovf", 64'(ov[1]), 64'd0);
    chk("plan u32 ovf", 64'(ov[0]), 64'd1);
    run(32'hFFFF_FFFF, 32'd1, 32'd0, -1, -1);
    run(32'd200, 32'd100, 32'd2, -1, -1);
    chk("plan u8 z", 64'(zo[3]), 64'd202);
    chk("plan u8 x", 64'(xo[3]), 64'd100);
    run(32'd7, 32'd9, 32'd11, 3, -1);
    run(32'h1234_5678, 32'd3, 32'd5, -1, 2);
    run(32'd5, 32'd3, 32'd2, -1, -1);

    for (int n = 0; n < 16; n++) begin
      if (n % 2 == 0) begin
        ra = $urandom;
        rb = $urandom;
        rc = $urandom;
      end else begin
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
        rc = $urandom_range(0, 15);
        if (n % 4 == 1) ra = ~ra;
      end
      run(ra, rb, rc, (n % 5 == 0) ? 3 : -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
